// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: state codes (also the seq_stat values seen by the host) and defaults
package frame_seq_pkg;
  localparam int C_TIMEOUT_DEF = 1000000;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT_EXP = 3'd1;
  localparam logic [2:0] S_READOUT = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR = 3'd5;
  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT_EXP = S_WAIT_EXP,
    ST_READOUT = S_READOUT,
    ST_RELEASE = S_RELEASE,
    ST_DONE = S_DONE,
    ST_ERR = S_ERR
  } seq_state_t;
  function automatic logic is_busy(input seq_state_t s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
  endfunction
endpackage

// File: rtl/seq_timeout_cnt.sv
// seq_timeout_cnt: loadable down-counter; tc marks the terminal count while enabled
module seq_timeout_cnt #(
  parameter int W = 20
) (
  input  logic         CLKMPRE,
  input  logic         RESET_N,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge CLKMPRE or negedge RESET_N)
    if (!RESET_N) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = en && cnt == '0;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: run-level controller for the exposure FSM, handing frames to the ADC readout
module frame_sequencer import frame_seq_pkg::*; #(
  parameter int C_TIMEOUT = C_TIMEOUT_DEF,
  parameter int C_CNT_W = 16
) (
  input  logic               CLKMPRE,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               ABORT,
  input  logic [C_CNT_W-1:0] NUM_FRAMES,
  output logic               cam_start,
  input  logic               FSMIND1,
  output logic               FSMIND1ACK,
  output logic               FSMIND0,
  input  logic               FSMIND0ACK,
  output logic               RO_START,
  input  logic               RO_DONE,
  output logic [C_CNT_W-1:0] FRAME_CNT,
  output logic               BUSY,
  output logic               RUN_DONE,
  output logic               TIMEOUT,
  output logic [2:0]         seq_stat
);
  localparam int TW = C_TIMEOUT > 2 ? $clog2(C_TIMEOUT) : 1;
  seq_state_t state, state_n;
  logic parked, parked_n, cam_start_n, ind1ack_n, ind0_n, ro_start_n, run_done_n, timeout_n;
  logic tc, to_err;
  logic [C_CNT_W-1:0] frame_cnt_n, lim_r, lim_n, cnt_inc;

  // reloaded on every state change, so each wait state gets a fresh budget
  seq_timeout_cnt #(.W(TW)) u_timeout (
    .CLKMPRE (CLKMPRE),
    .RESET_N (RESET_N),
    .clr     (ABORT),
    .load    (state_n != state),
    .load_val(TW'(C_TIMEOUT - 1)),
    .en      (state == ST_READOUT || state == ST_RELEASE),
    .tc      (tc)
  );

  assign to_err = tc && (state == ST_READOUT ? !RO_DONE : !FSMIND0ACK);
  assign BUSY = is_busy(state);
  assign seq_stat = state;

  always_comb begin
    state_n = state;
    parked_n = parked;
    cam_start_n = cam_start;
    ind1ack_n = FSMIND1ACK;
    ind0_n = FSMIND0;
    ro_start_n = 1'b0;
    run_done_n = 1'b0;
    timeout_n = TIMEOUT;
    frame_cnt_n = FRAME_CNT;
    lim_n = lim_r;
    cnt_inc = FRAME_CNT + 1'b1;
    if (ABORT) begin
      state_n = ST_IDLE;
      parked_n = 1'b0;
      cam_start_n = 1'b0;
      ind1ack_n = 1'b0;
      ind0_n = 1'b0;
      timeout_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (START) begin
          frame_cnt_n = '0;
          lim_n = NUM_FRAMES;
          cam_start_n = 1'b1;
          ind0_n = parked;
          state_n = parked ? ST_RELEASE : ST_WAIT_EXP;
        end
        ST_WAIT_EXP: if (FSMIND1) begin
          ind1ack_n = 1'b1;
          ro_start_n = 1'b1;
          state_n = ST_READOUT;
        end
        ST_READOUT: if (RO_DONE) begin
          frame_cnt_n = cnt_inc;
          // last frame: withhold FSMIND0 so the exposure FSM parks until the next run
          if (lim_r != '0 && cnt_inc == lim_r) begin
            state_n = ST_DONE;
            parked_n = 1'b1;
            cam_start_n = 1'b0;
            run_done_n = 1'b1;
          end else begin
            ind0_n = 1'b1;
            state_n = ST_RELEASE;
          end
        end
        ST_RELEASE: if (FSMIND0ACK) begin
          ind0_n = 1'b0;
          ind1ack_n = 1'b0;
          parked_n = 1'b0;
          state_n = ST_WAIT_EXP;
        end
        ST_ERR: ;
        default: state_n = ST_IDLE;
      endcase
      if (to_err) begin
        state_n = ST_ERR;
        cam_start_n = 1'b0;
        ind1ack_n = 1'b0;
        ind0_n = 1'b0;
        timeout_n = 1'b1;
      end
    end
  end

  always_ff @(posedge CLKMPRE or negedge RESET_N)
    if (!RESET_N) begin
      state <= ST_IDLE;
      parked <= 1'b0;
      cam_start <= 1'b0;
      FSMIND1ACK <= 1'b0;
      FSMIND0 <= 1'b0;
      RO_START <= 1'b0;
      RUN_DONE <= 1'b0;
      TIMEOUT <= 1'b0;
      FRAME_CNT <= '0;
      lim_r <= '0;
    end else begin
      state <= state_n;
      parked <= parked_n;
      cam_start <= cam_start_n;
      FSMIND1ACK <= ind1ack_n;
      FSMIND0 <= ind0_n;
      RO_START <= ro_start_n;
      RUN_DONE <= run_done_n;
      TIMEOUT <= timeout_n;
      FRAME_CNT <= frame_cnt_n;
      lim_r <= lim_n;
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of frame_sequencer against an exposure FSM and ADC model
module tb_frame_sequencer;
  localparam int TO = 50;
  localparam int CW = 8;
  logic CLKMPRE = 0, RESET_N = 0, START = 0, ABORT = 0;
  logic FSMIND1 = 0, FSMIND0ACK = 0, RO_DONE = 0;
  logic [CW-1:0] NUM_FRAMES = '0;
  logic cam_start, FSMIND1ACK, FSMIND0, RO_START, BUSY, RUN_DONE, TIMEOUT;
  logic [CW-1:0] FRAME_CNT;
  logic [2:0] seq_stat;
  logic exp_rst = 1, ro_rst = 1;
  int ro_delay = 20;
  int ro_pulses = 0, rd_pulses = 0;
  int checks = 0, errors = 0;

  frame_sequencer #(.C_TIMEOUT(TO), .C_CNT_W(CW)) dut (
    .CLKMPRE(CLKMPRE), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .NUM_FRAMES(NUM_FRAMES), .cam_start(cam_start), .FSMIND1(FSMIND1),
    .FSMIND1ACK(FSMIND1ACK), .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK),
    .RO_START(RO_START), .RO_DONE(RO_DONE), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY),
    .RUN_DONE(RUN_DONE), .TIMEOUT(TIMEOUT), .seq_stat(seq_stat)
  );

  always #5 CLKMPRE = ~CLKMPRE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // exposure FSM: request readout on cam_start, ack FSMIND0 five cycles after it rises
  initial begin : exposure_model
    int em, dly;
    em = 0;
    dly = 0;
    forever begin
      @(posedge CLKMPRE); #1;
      if (exp_rst) begin
        FSMIND1 = 0; FSMIND0ACK = 0; em = 0; dly = 0;
      end else case (em)
        0: if (cam_start) begin FSMIND1 = 1; em = 1; end
        1: if (FSMIND1ACK) begin FSMIND1 = 0; em = 2; dly = 0; end
        2: if (FSMIND0) begin dly++; if (dly == 5) begin FSMIND0ACK = 1; em = 3; end end
        3: if (!FSMIND0) begin FSMIND0ACK = 0; em = 0; end
        default: em = 0;
      endcase
    end
  end

  // ADC engine: RO_DONE pulse ro_delay cycles after RO_START; ro_delay 0 withholds it
  initial begin : readout_model
    int rt;
    rt = 0;
    forever begin
      @(posedge CLKMPRE); #1;
      RO_DONE = 0;
      if (ro_rst) rt = 0;
      else if (RO_START && ro_delay != 0) rt = ro_delay;
      else if (rt == 1) begin RO_DONE = 1; rt = 0; end
      else if (rt > 1) rt--;
    end
  end

  always @(negedge CLKMPRE) begin
    if (RO_START) ro_pulses++;
    if (RUN_DONE) rd_pulses++;
  end

  task automatic pulse_start(input logic [CW-1:0] n);
    NUM_FRAMES = n;
    START = 1;
    @(negedge CLKMPRE);
    START = 0;
  endtask

  task automatic do_abort();
    ABORT = 1; exp_rst = 1; ro_rst = 1;
    @(negedge CLKMPRE);
    ABORT = 0; exp_rst = 0; ro_rst = 0;
  endtask

  task automatic wait_stat(input logic [2:0] s, input string tag);
    int n = 0;
    while (seq_stat != s && n < 500) begin @(negedge CLKMPRE); n++; end
    chk(tag, seq_stat, s);
  endtask

  initial begin
    int n, base_ro, base_rd, busy_low;
    logic [CW-1:0] prev;
    repeat (3) @(negedge CLKMPRE);
    chk("rst_outs", {cam_start, FSMIND1ACK, FSMIND0, RO_START, BUSY, RUN_DONE, TIMEOUT, FRAME_CNT, seq_stat}, 0);
    RESET_N = 1; exp_rst = 0; ro_rst = 0;
    @(negedge CLKMPRE);

    // three-frame run; a mid-run START and NUM_FRAMES change must be ignored
    base_ro = ro_pulses; base_rd = rd_pulses;
    pulse_start(3);
    chk("t1_wait_exp", {seq_stat, cam_start, BUSY}, {3'd1, 1'b1, 1'b1});
    n = 0;
    while (FRAME_CNT != 1 && n < 500) begin @(negedge CLKMPRE); n++; end
    pulse_start(7);
    wait_stat(3'd4, "t1_done");
    repeat (10) @(negedge CLKMPRE);
    chk("t1_ro_pulses", ro_pulses - base_ro, 3);
    chk("t1_run_done", rd_pulses - base_rd, 1);
    chk("t1_final", {FRAME_CNT, cam_start, FSMIND0, BUSY, seq_stat}, {8'd3, 1'b0, 1'b0, 1'b0, 3'd4});

    // restart from DONE: parked exposure FSM is released first
    base_ro = ro_pulses; base_rd = rd_pulses;
    pulse_start(1);
    chk("t2_release", {seq_stat, FSMIND0, cam_start, FRAME_CNT}, {3'd3, 1'b1, 1'b1, 8'd0});
    NUM_FRAMES = 5;
    n = 0;
    while (!FSMIND1 && n < 200) begin @(negedge CLKMPRE); n++; end
    @(negedge CLKMPRE);
    chk("t2_ack_lat", {FSMIND1ACK, RO_START, seq_stat}, {1'b1, 1'b1, 3'd2});
    n = 0;
    while (!RO_DONE && n < 200) begin @(negedge CLKMPRE); n++; end
    @(negedge CLKMPRE);
    chk("t2_done", {seq_stat, RUN_DONE, FRAME_CNT, FSMIND0}, {3'd4, 1'b1, 8'd1, 1'b0});
    @(negedge CLKMPRE);
    chk("t2_run_done_pulse", RUN_DONE, 0);
    chk("t2_ro_pulses", ro_pulses - base_ro, 1);

    // free-run 300 frames: counter wraps, never done, always busy
    base_rd = rd_pulses; busy_low = 0; ro_delay = 3;
    pulse_start(0);
    for (int k = 1; k <= 300; k++) begin
      prev = FRAME_CNT;
      n = 0;
      while (FRAME_CNT == prev && n < 200) begin
        @(negedge CLKMPRE);
        n++;
        if (!BUSY) busy_low++;
      end
      if (k == 255) chk("t3_cnt255", FRAME_CNT, 255);
      if (k == 256) chk("t3_wrap", FRAME_CNT, 0);
    end
    chk("t3_cnt300", FRAME_CNT, 44);
    chk("t3_busy", busy_low, 0);
    chk("t3_no_run_done", rd_pulses - base_rd, 0);
    do_abort();
    chk("t3_abort", {seq_stat, cam_start, FSMIND0, FSMIND1ACK, FRAME_CNT}, {3'd0, 1'b0, 1'b0, 1'b0, 8'd44});

    // withheld RO_DONE: error after TO cycles in READOUT
    ro_delay = 0;
    pulse_start(0);
    wait_stat(3'd2, "t4_readout");
    n = 0;
    while (seq_stat == 2 && n < 200) begin @(negedge CLKMPRE); n++; end
    chk("t4_to_lat", n, TO);
    chk("t4_err", {seq_stat, TIMEOUT, cam_start, FSMIND1ACK, FSMIND0, BUSY}, {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    pulse_start(2);
    repeat (2) @(negedge CLKMPRE);
    chk("t4_err_hold", {seq_stat, TIMEOUT}, {3'd5, 1'b1});
    do_abort();
    chk("t4_abort", {seq_stat, TIMEOUT}, 0);

    // RO_DONE lands on the terminal count: readout completes normally
    ro_delay = TO - 1;
    pulse_start(0);
    wait_stat(3'd2, "t5_readout");
    n = 0;
    while (seq_stat == 2 && n < 200) begin @(negedge CLKMPRE); n++; end
    chk("t5_race_lat", n, TO);
    chk("t5_release", {seq_stat, FSMIND0, TIMEOUT, FRAME_CNT}, {3'd3, 1'b1, 1'b0, 8'd1});
    do_abort();

    // START together with ABORT: ABORT wins, count untouched
    NUM_FRAMES = 2; START = 1; ABORT = 1; exp_rst = 1; ro_rst = 1;
    @(negedge CLKMPRE);
    START = 0; ABORT = 0; exp_rst = 0; ro_rst = 0;
    repeat (3) @(negedge CLKMPRE);
    chk("t6_start_abort", {seq_stat, cam_start, BUSY, FRAME_CNT}, {3'd0, 1'b0, 1'b0, 8'd1});

    // async reset in the middle of READOUT
    ro_delay = 3;
    pulse_start(0);
    n = 0;
    while (!(seq_stat == 2 && FRAME_CNT == 2) && n < 500) begin @(negedge CLKMPRE); n++; end
    chk("t7_mid_readout", {seq_stat, FRAME_CNT, FSMIND1ACK}, {3'd2, 8'd2, 1'b1});
    #2 RESET_N = 0; exp_rst = 1; ro_rst = 1;
    #1 chk("t7_async_rst", {cam_start, FSMIND1ACK, FSMIND0, RO_START, BUSY, RUN_DONE, TIMEOUT, FRAME_CNT, seq_stat}, 0);
    @(negedge CLKMPRE);
    RESET_N = 1; exp_rst = 0; ro_rst = 0;
    repeat (2) @(negedge CLKMPRE);
    chk("t7_idle", {seq_stat, cam_start}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Run-level controller for the exposure FSM (CLKMPRE domain), sitting between the host register file and that FSM.
- Starts the FSM, services its FSMIND1/FSMIND1ACK and FSMIND0/FSMIND0ACK readout handshake, and hands each frame to the ADC readout engine via RO_START/RO_DONE.
- Counts frames, stops after a programmed number, and flags handshake timeouts.

Parameters:
- C_TIMEOUT, 1000000: CLKMPRE cycles allowed in READOUT or RELEASE before a timeout.
- C_CNT_W, 16: width of the frame count and limit.

Ports:
- CLKMPRE  in  1  Sequencer clock, same clock as the exposure FSM.
- RESET_N  in  1  Asynchronous active-low reset.
- START  in  1  Host start pulse, one cycle; accepted in IDLE and DONE only.
- ABORT  in  1  Host abort, level; has priority over everything except reset.
- NUM_FRAMES  in  C_CNT_W  Frames per run; 0 means free-run.
- cam_start  out  1  Level start to the exposure FSM.
- FSMIND1  in  1  Exposure FSM: frame exposed, readout requested.
- FSMIND1ACK  out  1  Acknowledge of FSMIND1.
- FSMIND0  out  1  Readout finished, exposure FSM may start the next frame.
- FSMIND0ACK  in  1  Exposure FSM acknowledge of FSMIND0.
- RO_START  out  1  One-cycle pulse to the ADC readout engine.
- RO_DONE  in  1  ADC readout complete, pulse or level.
- FRAME_CNT  out  C_CNT_W  Frames read out in the current run; wraps.
- BUSY  out  1  High in every state except IDLE, DONE and ERR.
- RUN_DONE  out  1  One-cycle pulse on entering DONE.
- TIMEOUT  out  1  Sticky error flag.
- seq_stat  out  3  Current state encoding.

Behaviour:
- Reset values: all outputs 0; state IDLE; parked flag 0.
- States and encodings:
  - IDLE=0: on START, clear FRAME_CNT and latch NUM_FRAMES into lim_r, then:
    - parked=1: go to RELEASE.
    - parked=0: go to WAIT_EXP, and cam_start goes to 1 registered, i.e. on the cycle after START.
  - WAIT_EXP=1: hold cam_start=1. On FSMIND1=1, set FSMIND1ACK=1, pulse RO_START for exactly 1 cycle, go to READOUT.
  - READOUT=2: hold FSMIND1ACK=1 and run the timeout counter. On RO_DONE=1:
    - increment FRAME_CNT.
    - lim_r!=0 and FRAME_CNT+1==lim_r: go to DONE, set parked=1, cam_start=0, FSMIND0 stays 0 (exposure FSM stays parked waiting for FSMIND0).
    - otherwise: set FSMIND0=1 and go to RELEASE.
  - RELEASE=3: hold FSMIND0=1 and cam_start=1. On FSMIND0ACK=1, set FSMIND0=0, FSMIND1ACK=0, parked=0, go to WAIT_EXP.
  - DONE=4: on START, same action as IDLE with parked=1.
  - ERR=5: all handshake outputs 0, cam_start=0; TIMEOUT=1; leave only via ABORT or reset.
  - Encodings 6 and 7 recover to IDLE.
- Timeout:
  - The counter clears on every state change.
  - Reaching C_TIMEOUT-1 in READOUT or RELEASE → ERR.
- ABORT (level, any state):
  - Next cycle: state IDLE; cam_start, FSMIND0, FSMIND1ACK and RO_START=0; TIMEOUT cleared; parked cleared; FRAME_CNT held.
  - The host must reset the exposure FSM alongside ABORT.
- Simultaneous events:
  - START and ABORT together: ABORT wins.
  - RO_DONE in the same cycle as the timeout terminal count: RO_DONE wins.
  - START outside IDLE/DONE is ignored.
- Arithmetic:
  - FRAME_CNT wraps from 2^C_CNT_W-1 to 0 without error; the stop compare uses the registered lim_r only.
  - Changing NUM_FRAMES mid-run has no effect.
- Latency:
  - FSMIND1 rising → FSMIND1ACK and RO_START: 1 cycle.
  - RO_DONE → FSMIND0: 1 cycle.
- Async reset mid-run: all outputs drop immediately. The exposure FSM must be reset by the same event.

Decomposition:
- Shared package frame_seq_pkg holds:
  - state encodings S_IDLE…S_ERR as localparams, 3-bit;
  - C_TIMEOUT default;
  - seq_stat code meanings.
- One sub-module, seq_timeout_cnt: a loadable down-counter with clear, enable and terminal-count output, reused for both wait states.

Test Plan:
- NUM_FRAMES=3, exposure model raises FSMIND1 and returns FSMIND0ACK after 5 cycles, RO_DONE 20 cycles after RO_START → exactly 3 RO_START pulses, FRAME_CNT=3, RUN_DONE pulse once, cam_start=0, FSMIND0 stays 0 after frame 3.
- After the above, START again with NUM_FRAMES=1 → FSMIND0 asserted first (RELEASE), then FSMIND1ACK/RO_START once, FRAME_CNT=1, DONE.
- NUM_FRAMES=0, run 300 frames with C_CNT_W=8 → FRAME_CNT wraps 255→0 at frame 256, no RUN_DONE, BUSY stays 1.
- C_TIMEOUT=50, RO_DONE withheld → ERR entered 50 cycles after READOUT entry, TIMEOUT=1, cam_start=0; ABORT → IDLE, TIMEOUT=0.
- RO_DONE in the exact timeout-terminal cycle → RELEASE entered, TIMEOUT stays 0.
- START and ABORT in the same cycle → state stays IDLE; RESET_N pulsed low mid-READOUT → all outputs 0 asynchronously, state IDLE.
